// File: rtl/prefix_adder_pipe_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder.
package prefix_adder_pipe_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // Black cell: merge a high group with the adjacent low group.
  function automatic pg_t black(input pg_t h, input pg_t l);
    pg_t r;
    r.g = h.g | (h.p & l.g);
    r.p = h.p & l.p;
    return r;
  endfunction

  // Gray cell: only the group generate is needed (low side is a carry).
  function automatic logic gray(input pg_t h, input logic gl);
    return h.g | (h.p & gl);
  endfunction

  // Number of registered prefix stages for a given width and levels per stage.
  function automatic int unsigned num_levels(input int unsigned width, input int unsigned lreg);
    return ($clog2(width) + lreg - 1) / lreg;
  endfunction

  // Span of prefix level i.
  function automatic int unsigned lvl_span(input int unsigned lvl);
    return 32'd1 << lvl;
  endfunction

endpackage

// File: rtl/prefix_adder_pipe_if.sv
// Valid/ready operand and result stream for prefix_adder_pipe.
interface prefix_adder_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/prefix_adder_pipe_ks_prefix_stage.sv
// One registered group of Kogge-Stone prefix levels with its valid bit.
// Side data (raw propagate, carry-in) rides along unchanged.
module ks_prefix_stage
  import prefix_adder_pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FIRST_LVL = 0,
  parameter int unsigned NLVL      = 1,
  parameter int unsigned SW        = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_adv,
  input  logic                 i_valid,
  input  pg_t  [WIDTH-1:0]     i_pg,
  input  logic [SW-1:0]        i_side,
  output logic                 o_valid,
  output pg_t  [WIDTH-1:0]     o_pg,
  output logic [SW-1:0]        o_side
);

  pg_t  [WIDTH-1:0] w_lvl [NLVL+1];
  logic             r_valid;
  pg_t  [WIDTH-1:0] r_pg;
  logic [SW-1:0]    r_side;

  // Combinational prefix levels: bit j merges with bit j-span where it exists.
  always_comb begin
    int unsigned span;
    w_lvl    = '{default: '0};
    w_lvl[0] = i_pg;
    for (int unsigned l = 0; l < NLVL; l++) begin
      span = lvl_span(FIRST_LVL + l);
      for (int unsigned j = 0; j < WIDTH; j++) begin
        if (j >= span) w_lvl[l+1][j] = black(w_lvl[l][j], w_lvl[l][j-span]);
        else           w_lvl[l+1][j] = w_lvl[l][j];
      end
    end
  end

  // Stage register; moves only on global advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pg    <= '0;
      r_side  <= '0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      r_pg    <= w_lvl[NLVL];
      r_side  <= i_side;
    end
  end

  assign o_valid = r_valid;
  assign o_pg    = r_pg;
  assign o_side  = r_side;

endmodule

// File: rtl/prefix_adder_pipe.sv
// Fully pipelined Kogge-Stone adder/subtractor with valid/ready stream and
// cout/ovf/zero flags. Optional macro ADDER_SAT_EN saturates on signed overflow.
module prefix_adder_pipe
  import prefix_adder_pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned LEVEL_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  prefix_adder_pipe_if.slave  io_bus
);

  localparam int unsigned LOG2W = $clog2(WIDTH);
  localparam int unsigned NL    = num_levels(WIDTH, LEVEL_REG);
  localparam int unsigned SW    = WIDTH + 1;  // {cin', raw propagate}

  logic             r_init;
  logic             w_adv;
  logic             w_accept;
  logic             w_cin;
  logic [WIDTH-1:0] w_b;
  pg_t  [WIDTH-1:0] w_pg0;
  logic [SW-1:0]    w_side0;

  logic             w_v    [NL+1];
  pg_t  [WIDTH-1:0] w_pg   [NL+1];
  logic [SW-1:0]    w_side [NL+1];

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p_last;
  logic             w_unused_p;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  assign w_adv           = !r_out_valid || io_bus.out_ready;
  assign io_bus.in_ready = r_init && w_adv;
  assign w_accept        = io_bus.in_valid && r_init && w_adv;
  assign w_b             = io_bus.sub ? ~io_bus.b : io_bus.b;
  assign w_cin           = io_bus.sub | io_bus.cin;

  // Holds in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_init <= 1'b0;
    else        r_init <= 1'b1;
  end

  // Bit-level PG; carry-in is folded into bit 0 so its group never needs it again.
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_pg0[i].g = io_bus.a[i] & w_b[i];
      w_pg0[i].p = io_bus.a[i] ^ w_b[i];
    end
    w_pg0[0].g = gray(w_pg0[0], w_cin);
    w_pg0[0].p = 1'b0;
    w_side0    = {w_cin, io_bus.a ^ w_b};
  end

  // S0 register: captures the accepted beat (or a bubble) on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_v[0]    <= 1'b0;
      w_pg[0]   <= '0;
      w_side[0] <= '0;
    end else if (w_adv) begin
      w_v[0]    <= w_accept;
      w_pg[0]   <= w_pg0;
      w_side[0] <= w_side0;
    end
  end

  for (genvar k = 0; k < NL; k++) begin : g_stage
    localparam int unsigned LO  = k * LEVEL_REG;
    localparam int unsigned NLV = (LOG2W - LO < LEVEL_REG) ? LOG2W - LO : LEVEL_REG;
    ks_prefix_stage #(
      .WIDTH    (WIDTH),
      .FIRST_LVL(LO),
      .NLVL     (NLV),
      .SW       (SW)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_adv  (w_adv),
      .i_valid(w_v[k]),
      .i_pg   (w_pg[k]),
      .i_side (w_side[k]),
      .o_valid(w_v[k+1]),
      .o_pg   (w_pg[k+1]),
      .o_side (w_side[k+1])
    );
  end

  // Sum stage: carries are group generates shifted up with cin' at bit 0.
  always_comb begin
    w_g      = '0;
    w_p_last = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_g[i]      = w_pg[NL][i].g;
      w_p_last[i] = w_pg[NL][i].p;
    end
    w_carry = {w_g[WIDTH-2:0], w_side[NL][WIDTH]};
    w_sum   = w_side[NL][WIDTH-1:0] ^ w_carry;
    w_ovf   = w_g[WIDTH-1] ^ w_g[WIDTH-2];
`ifdef ADDER_SAT_EN
    // On overflow the wrapped MSB is the inverse of the true sign.
    if (w_ovf) w_sum = w_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
  end

  assign w_unused_p = ^w_p_last;

  // Output register: held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_v[NL];
      r_sum       <= w_sum;
      r_cout      <= w_g[WIDTH-1];
      r_ovf       <= w_ovf;
      r_zero      <= ~|w_sum;
    end
  end

  assign io_bus.out_valid = r_out_valid;
  assign io_bus.sum       = r_sum;
  assign io_bus.cout      = r_cout;
  assign io_bus.ovf       = r_ovf;
  assign io_bus.zero      = r_zero;

endmodule
